// File: rtl/parity_pkg.sv
// Shared types and constants for the XOR-parity serial link (checker and future generator).
package parity_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

  localparam int ERR_CNT_W = 16;

endpackage

// File: rtl/serial_parity_checker_if.sv
// Bit-stream input and frame-result output bundle of the parity checker.
// The err_cnt signal exists only when PARITY_ERR_CNT_EN is defined.
interface serial_parity_checker_if #(
  parameter int DATA_W = 8
);
  import parity_pkg::*;

  logic              in_valid;
  logic              in_sof;
  logic              in_bit;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              parity_err;
  logic              frame_abort;
  logic              busy;
`ifdef PARITY_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt;
`endif

  modport master (
`ifdef PARITY_ERR_CNT_EN
    input  err_cnt,
`endif
    output in_valid, in_sof, in_bit,
    input  out_data, out_valid, parity_err, frame_abort, busy
  );

  modport slave (
`ifdef PARITY_ERR_CNT_EN
    output err_cnt,
`endif
    input  in_valid, in_sof, in_bit,
    output out_data, out_valid, parity_err, frame_abort, busy
  );

endinterface

// File: rtl/parity_acc.sv
// Clocked single-bit XOR accumulator; clr has priority over load, load over en.
module parity_acc (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic load,
  input  logic en,
  input  logic din,
  output logic acc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       acc <= 1'b0;
    else if (clr)  acc <= 1'b0;
    else if (load) acc <= din;
    else if (en)   acc <= acc ^ din;
  end

endmodule

// File: rtl/serial_parity_checker.sv
// Receive side of the XOR-parity serial link: LSB-first deserialiser plus parity check.
// Optional PARITY_ERR_CNT_EN adds a saturating parity-error counter on the bus.
module serial_parity_checker
  import parity_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  serial_parity_checker_if.slave  bus
);

  localparam int               CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_p0;
  logic              acc;
  logic              acc_clr, acc_load, acc_en, shift_en;
  logic              done, abort, chk;
  logic              vld_p1, abort_p1, perr_p1;
  logic [DATA_W-1:0] data_p1;

  parity_acc u_acc (
    .clk  (clk),
    .rst  (rst),
    .clr  (acc_clr),
    .load (acc_load),
    .en   (acc_en),
    .din  (bus.in_bit),
    .acc  (acc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // An accepted in_sof always restarts the frame, whatever state we are in.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_clr  = 1'b0;
    acc_load = 1'b0;
    acc_en   = 1'b0;
    shift_en = 1'b0;
    done     = 1'b0;
    abort    = 1'b0;
    if (bus.in_valid) begin
      if (bus.in_sof) begin
        abort    = (state_q != ST_IDLE);
        acc_load = 1'b1;
        shift_en = 1'b1;
        cnt_d    = CNT_W'(1);
        state_d  = ST_DATA;
      end else begin
        case (state_q)
          ST_DATA: begin
            shift_en = 1'b1;
            acc_en   = 1'b1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_d == CNT_LAST) state_d = ST_PARITY;
          end
          ST_PARITY: begin
            done    = 1'b1;
            acc_clr = 1'b1;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  assign chk = acc ^ bus.in_bit ^ PARITY_ODD;

  // Stage p0: shift right so the first (LSB) bit lands in bit 0 after DATA_W shifts.
  always_ff @(posedge clk) begin
    if (shift_en) shreg_p0 <= {bus.in_bit, shreg_p0[DATA_W-1:1]};
  end

  // Stage p1: frame result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      abort_p1 <= 1'b0;
      perr_p1  <= 1'b0;
      data_p1  <= '0;
    end else begin
      vld_p1   <= done;
      abort_p1 <= abort;
      if (done) begin
        data_p1 <= shreg_p0;
        perr_p1 <= chk;
      end
    end
  end

  assign bus.out_data    = data_p1;
  assign bus.out_valid   = vld_p1;
  assign bus.parity_err  = perr_p1;
  assign bus.frame_abort = abort_p1;
  assign bus.busy        = (state_q != ST_IDLE);

`ifdef PARITY_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + ERR_CNT_W'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              err_cnt_q <= '0;
    else if (done && chk) err_cnt_q <= sat_inc(err_cnt_q);
  end

  assign bus.err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_serial_parity_checker.sv
// Directed bench for serial_parity_checker: even-parity DUT plus an odd-parity twin on the same stimulus.
// The err_cnt scenario is compiled only with PARITY_ERR_CNT_EN.
module tb_serial_parity_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   vcnt = 0, acnt = 0, both_cnt = 0;

  always #5 clk = ~clk;

  serial_parity_checker_if #(.DATA_W(8)) bus0 ();
  serial_parity_checker_if #(.DATA_W(8)) bus1 ();

  serial_parity_checker #(.DATA_W(8), .PARITY_ODD(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  serial_parity_checker #(.DATA_W(8), .PARITY_ODD(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always @(posedge clk) begin
    if (bus0.out_valid) vcnt <= vcnt + 1;
    if (bus0.frame_abort) acnt <= acnt + 1;
    if (bus0.out_valid && bus0.frame_abort) both_cnt <= both_cnt + 1;
  end

  task automatic drive(input logic v, input logic s, input logic b);
    bus0.in_valid = v; bus0.in_sof = s; bus0.in_bit = b;
    bus1.in_valid = v; bus1.in_sof = s; bus1.in_bit = b;
    @(posedge clk); #1;
  endtask

  task automatic send_bits(input logic [7:0] d);
    for (int i = 0; i < 8; i++) drive(1'b1, i == 0, d[i]);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #2;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 1'b0);
    n_cmp++; if (bus0.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %0b want 0", bus0.out_valid); end
    n_cmp++; if (bus0.out_data !== 8'h00) begin n_fail++; $display("FAIL rst_data got %h want 00", bus0.out_data); end
    n_cmp++; if (bus0.parity_err !== 1'b0) begin n_fail++; $display("FAIL rst_perr got %0b want 0", bus0.parity_err); end
    n_cmp++; if (bus0.frame_abort !== 1'b0) begin n_fail++; $display("FAIL rst_abort got %0b want 0", bus0.frame_abort); end
    n_cmp++; if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %0b want 0", bus0.busy); end
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b1);
    n_cmp++; if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL idle_nosof_busy got %0b want 0", bus0.busy); end
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_good_frame();
    send_bits(8'hA5);
    n_cmp++; if (bus0.out_valid !== 1'b0) begin n_fail++; $display("FAIL good_early_valid got %0b want 0", bus0.out_valid); end
    n_cmp++; if (bus0.busy !== 1'b1) begin n_fail++; $display("FAIL good_busy got %0b want 1", bus0.busy); end
    drive(1'b1, 1'b0, 1'b0);
    n_cmp++; if (bus0.out_valid !== 1'b1) begin n_fail++; $display("FAIL good_valid got %0b want 1", bus0.out_valid); end
    n_cmp++; if (bus0.out_data !== 8'hA5) begin n_fail++; $display("FAIL good_data got %h want a5", bus0.out_data); end
    n_cmp++; if (bus0.parity_err !== 1'b0) begin n_fail++; $display("FAIL good_perr got %0b want 0", bus0.parity_err); end
    n_cmp++; if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL good_busy_fall got %0b want 0", bus0.busy); end
    n_cmp++; if (bus1.parity_err !== 1'b1) begin n_fail++; $display("FAIL odd_good_perr got %0b want 1", bus1.parity_err); end
    drive(1'b0, 1'b0, 1'b0);
    n_cmp++; if (bus0.out_valid !== 1'b0) begin n_fail++; $display("FAIL good_pulse_len got %0b want 0", bus0.out_valid); end
    n_cmp++; if (bus0.out_data !== 8'hA5) begin n_fail++; $display("FAIL good_data_hold got %h want a5", bus0.out_data); end
  endtask

  task automatic test_bad_parity();
    send_bits(8'hA5);
    drive(1'b1, 1'b0, 1'b1);
    n_cmp++; if (bus0.out_data !== 8'hA5) begin n_fail++; $display("FAIL bad_data got %h want a5", bus0.out_data); end
    n_cmp++; if (bus0.parity_err !== 1'b1) begin n_fail++; $display("FAIL bad_perr got %0b want 1", bus0.parity_err); end
    n_cmp++; if (bus1.parity_err !== 1'b0) begin n_fail++; $display("FAIL odd_bad_perr got %0b want 0", bus1.parity_err); end
    drive(1'b0, 1'b0, 1'b0);
    n_cmp++; if (bus0.parity_err !== 1'b1) begin n_fail++; $display("FAIL bad_perr_hold got %0b want 1", bus0.parity_err); end
  endtask

  task automatic test_gaps();
    logic [7:0] d;
    int busy_low;
    int v0;
    d = 8'h3C;
    busy_low = 0;
    v0 = vcnt;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, i == 0, d[i]);
      if (bus0.busy !== 1'b1) busy_low++;
      for (int g = 0; g < i % 4; g++) begin
        drive(1'b0, 1'b0, 1'b1);
        if (bus0.busy !== 1'b1) busy_low++;
      end
    end
    n_cmp++; if (busy_low !== 0) begin n_fail++; $display("FAIL gap_busy low_cycles=%0d want 0", busy_low); end
    drive(1'b1, 1'b0, 1'b0);
    n_cmp++; if (bus0.out_valid !== 1'b1) begin n_fail++; $display("FAIL gap_valid got %0b want 1", bus0.out_valid); end
    n_cmp++; if (bus0.out_data !== 8'h3C) begin n_fail++; $display("FAIL gap_data got %h want 3c", bus0.out_data); end
    n_cmp++; if (bus0.parity_err !== 1'b0) begin n_fail++; $display("FAIL gap_perr got %0b want 0", bus0.parity_err); end
    drive(1'b0, 1'b0, 1'b0);
    n_cmp++; if (vcnt - v0 !== 1) begin n_fail++; $display("FAIL gap_vcount got %0d want 1", vcnt - v0); end
  endtask

  task automatic test_abort();
    int v0, a0;
    v0 = vcnt; a0 = acnt;
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    n_cmp++; if (bus0.frame_abort !== 1'b1) begin n_fail++; $display("FAIL abort_pulse got %0b want 1", bus0.frame_abort); end
    n_cmp++; if (bus0.out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_novalid got %0b want 0", bus0.out_valid); end
    n_cmp++; if (bus0.busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy got %0b want 1", bus0.busy); end
    drive(1'b1, 1'b0, 1'b1);
    n_cmp++; if (bus0.frame_abort !== 1'b0) begin n_fail++; $display("FAIL abort_len got %0b want 0", bus0.frame_abort); end
    for (int i = 2; i < 8; i++) drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    n_cmp++; if (bus0.out_valid !== 1'b1) begin n_fail++; $display("FAIL abort_valid got %0b want 1", bus0.out_valid); end
    n_cmp++; if (bus0.out_data !== 8'hFF) begin n_fail++; $display("FAIL abort_data got %h want ff", bus0.out_data); end
    n_cmp++; if (bus0.parity_err !== 1'b0) begin n_fail++; $display("FAIL abort_perr got %0b want 0", bus0.parity_err); end
    drive(1'b0, 1'b0, 1'b0);
    n_cmp++; if (acnt - a0 !== 1) begin n_fail++; $display("FAIL abort_count got %0d want 1", acnt - a0); end
    n_cmp++; if (vcnt - v0 !== 1) begin n_fail++; $display("FAIL abort_vcount got %0d want 1", vcnt - v0); end
  endtask

  task automatic test_reset_mid();
    int v0, a0;
    drive(1'b1, 1'b1, 1'b1);
    for (int i = 1; i < 5; i++) drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    v0 = vcnt; a0 = acnt;
    rst = 1'b1;
    #2;
    n_cmp++; if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %0b want 0", bus0.busy); end
    n_cmp++; if (bus0.out_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_data got %h want 00", bus0.out_data); end
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    send_bits(8'h81);
    drive(1'b1, 1'b0, 1'b0);
    n_cmp++; if (bus0.out_data !== 8'h81) begin n_fail++; $display("FAIL rstmid_data2 got %h want 81", bus0.out_data); end
    n_cmp++; if (bus0.parity_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_perr got %0b want 0", bus0.parity_err); end
    drive(1'b0, 1'b0, 1'b0);
    n_cmp++; if (vcnt - v0 !== 1) begin n_fail++; $display("FAIL rstmid_vcount got %0d want 1", vcnt - v0); end
    n_cmp++; if (acnt - a0 !== 0) begin n_fail++; $display("FAIL rstmid_acount got %0d want 0", acnt - a0); end
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = vcnt;
    send_bits(8'h01);
    drive(1'b1, 1'b0, 1'b1);
    n_cmp++; if (bus0.parity_err !== 1'b0) begin n_fail++; $display("FAIL b2b_perr1 got %0b want 0", bus0.parity_err); end
    send_bits(8'h02);
    n_cmp++; if (bus0.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy got %0b want 1", bus0.busy); end
    drive(1'b1, 1'b0, 1'b0);
    n_cmp++; if (bus0.out_data !== 8'h02) begin n_fail++; $display("FAIL b2b_data2 got %h want 02", bus0.out_data); end
    n_cmp++; if (bus0.parity_err !== 1'b1) begin n_fail++; $display("FAIL b2b_perr2 got %0b want 1", bus0.parity_err); end
    drive(1'b0, 1'b0, 1'b0);
    n_cmp++; if (vcnt - v0 !== 2) begin n_fail++; $display("FAIL b2b_vcount got %0d want 2", vcnt - v0); end
    n_cmp++; if (both_cnt !== 0) begin n_fail++; $display("FAIL valid_abort_overlap got %0d want 0", both_cnt); end
  endtask

`ifdef PARITY_ERR_CNT_EN
  task automatic test_err_cnt();
    pulse_rst();
    n_cmp++; if (bus0.err_cnt !== 16'h0000) begin n_fail++; $display("FAIL errcnt_rst got %h want 0000", bus0.err_cnt); end
    send_bits(8'h01); drive(1'b1, 1'b0, 1'b0);
    send_bits(8'h03); drive(1'b1, 1'b0, 1'b1);
    send_bits(8'h07); drive(1'b1, 1'b0, 1'b0);
    send_bits(8'h0F); drive(1'b1, 1'b0, 1'b0);
    send_bits(8'h1F); drive(1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    n_cmp++; if (bus0.err_cnt !== 16'd3) begin n_fail++; $display("FAIL errcnt_three got %0d want 3", bus0.err_cnt); end
    force dut0.err_cnt_q = 16'hFFFF;
    #1;
    release dut0.err_cnt_q;
    send_bits(8'h01); drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    n_cmp++; if (bus0.err_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL errcnt_sat got %h want ffff", bus0.err_cnt); end
  endtask
`endif

  initial begin
    bus0.in_valid = 1'b0; bus0.in_sof = 1'b0; bus0.in_bit = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_sof = 1'b0; bus1.in_bit = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_good_frame();
    test_bad_parity();
    test_gaps();
    test_abort();
    test_reset_mid();
    test_back_to_back();
`ifdef PARITY_ERR_CNT_EN
    test_err_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
